// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered bitwise logic unit with valid/ready handshake, result flags and result feedback
module logic_unit_pipe #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic             use_prev,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             flag_z,
   output logic             flag_p,
   output logic             flag_n
);
   logic [WIDTH-1:0] prev, b_eff, r;
   logic acc;
   assign in_ready = !out_valid || out_ready;
   assign acc      = in_valid && in_ready;
   // prev tracks the last accepted result, even while it is still stalled at y
   assign b_eff    = use_prev ? prev : b;
   always_comb begin
      case (op)
         3'd0:    r = a & b_eff;
         3'd1:    r = a | b_eff;
         3'd2:    r = a ^ b_eff;
         3'd3:    r = ~(a | b_eff);
         3'd4:    r = ~(a & b_eff);
         3'd5:    r = ~(a ^ b_eff);
         3'd6:    r = ~a;
         default: r = a;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         y         <= '0;
         prev      <= '0;
         flag_z    <= 1'b1;
         flag_p    <= 1'b0;
         flag_n    <= 1'b0;
      end else if (acc) begin
         out_valid <= 1'b1;
         y         <= r;
         prev      <= r;
         flag_z    <= r == '0;
         flag_p    <= ^r;
         flag_n    <= r[WIDTH-1];
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: random and directed checks of logic_unit_pipe against a one-slot reference model
module tb_logic_unit_pipe;
   logic clk = 0, rst_n = 0;
   logic in_valid = 0, in_ready, use_prev = 0, out_valid, out_ready = 0;
   logic flag_z, flag_p, flag_n;
   logic [2:0] op = 0;
   logic [7:0] a = 0, b = 0, y;
   logic in_valid16 = 0, in_ready16, out_valid16, out_ready16 = 0;
   logic [2:0] op16 = 0;
   logic [15:0] a16 = 0, b16 = 0, y16;
   logic z16, p16, n16;
   int total = 0, bad = 0;
   logic       m_valid = 0;
   logic [7:0] m_y = 0, m_prev = 0;
   logic [7:0] exp2 [8];

   always #5 clk = ~clk;

   logic_unit_pipe #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .use_prev(use_prev), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .flag_z(flag_z), .flag_p(flag_p), .flag_n(flag_n));

   logic_unit_pipe #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16), .op(op16),
      .use_prev(1'b0), .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
      .y(y16), .flag_z(z16), .flag_p(p16), .flag_n(n16));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] ref_f(input int o, input logic [7:0] x, input logic [7:0] w);
      case (o)
         0: return x & w;
         1: return x | w;
         2: return x ^ w;
         3: return 8'hFF - (x | w);
         4: return 8'hFF - (x & w);
         5: return 8'hFF - (x ^ w);
         6: return 8'hFF - x;
         default: return x;
      endcase
   endfunction

   task automatic step(input string tag);
      logic rdy, acc;
      logic [7:0] r;
      #1;
      rdy = !m_valid || out_ready;
      check({tag, ".in_ready"}, in_ready, rdy);
      acc = in_valid && rdy;
      r = ref_f(int'(op), a, use_prev ? m_prev : b);
      @(posedge clk);
      #1;
      if (acc) begin
         m_valid = 1; m_y = r; m_prev = r;
      end else if (out_ready) m_valid = 0;
      check({tag, ".out_valid"}, out_valid, m_valid);
      check({tag, ".y"}, y, m_y);
      check({tag, ".flags"}, {flag_z, flag_p, flag_n},
            {m_y == 0, $countones(m_y) % 2 == 1, m_y >= 8'h80});
   endtask

   initial begin
      exp2 = '{8'h30, 8'hFC, 8'hCC, 8'h03, 8'hCF, 8'h33, 8'h0F, 8'hF0};
      #23 rst_n = 0;
      #1;
      check("reset.out_valid", out_valid, 0);
      check("reset.y", y, 0);
      check("reset.flag_z", flag_z, 1);
      check("reset.in_ready", in_ready, 1);
      @(posedge clk); #1 rst_n = 1;
      // every op on fixed operands
      out_ready = 1; in_valid = 1; a = 8'hF0; b = 8'h3C;
      for (int i = 0; i < 8; i++) begin
         op = 3'(i);
         step("ops");
         check("ops.const", y, exp2[i]);
      end
      // chained XOR then AND with feedback
      op = 2; a = 8'hAA; b = 8'h0F; step("chain1");
      check("chain1.const", y, 8'hA5);
      op = 0; use_prev = 1; a = 8'hF0; b = 8'h00; step("chain2");
      check("chain2.const", y, 8'hA0);
      use_prev = 0; in_valid = 0; step("drain");
      // backpressure
      in_valid = 1; op = 1; a = 8'h11; b = 8'h22; out_ready = 0; step("bp.acc");
      op = 7; a = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         step("bp.stall");
         check("bp.hold", y, 8'h33);
      end
      out_ready = 1; step("bp.rel");
      check("bp.second", y, 8'h5A);
      // full throughput
      for (int i = 0; i < 16; i++) begin
         op = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
         use_prev = 1'($urandom);
         step("thru");
         check("thru.valid", out_valid, 1);
      end
      // random handshakes
      for (int i = 0; i < 300; i++) begin
         op = 3'($urandom_range(0, 7)); a = 8'($urandom); b = 8'($urandom);
         use_prev = 1'($urandom); in_valid = 1'($urandom); out_ready = 1'($urandom);
         step("rand");
      end
      // 16-bit instance: NOR of zeros, then reset during stall
      in_valid16 = 1; op16 = 3; out_ready16 = 0;
      @(posedge clk); #1 in_valid16 = 0;
      check("w16.y", y16, 16'hFFFF);
      check("w16.nz", {n16, p16, z16}, 3'b100);
      check("w16.valid", out_valid16, 1);
      @(posedge clk); #3 rst_n = 0;
      #1;
      check("w16.rst_valid", out_valid16, 0);
      check("w16.rst_y", y16, 0);
      check("w16.rst_z", z16, 1);
      @(posedge clk); #1 rst_n = 1;
      @(posedge clk); #1;
      check("w16.dropped", out_valid16, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
